// File: rtl/riscv_lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 size codes, FSM states
// and byte-lane helpers.
package riscv_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;
  localparam logic [2:0] F3_XX = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } lsu_state_e;

  function automatic int lsu_dw_bytes(input int dw);
    return dw / 8;
  endfunction

  // Byte-enable pattern for an access of 1 << sz bytes at lane 0.
  function automatic logic [7:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'b00:   return 8'h01;
      2'b01:   return 8'h03;
      2'b10:   return 8'h0f;
      default: return 8'hff;
    endcase
  endfunction

  // Address bits that must be zero for a naturally aligned access.
  function automatic logic [7:0] align_mask(input logic [1:0] sz);
    case (sz)
      2'b00:   return 8'h00;
      2'b01:   return 8'h01;
      2'b10:   return 8'h03;
      default: return 8'h07;
    endcase
  endfunction

endpackage

// File: rtl/riscv_lsu_align.sv
// Combinational byte-lane steering: byte enables, shifted store data,
// extended load data and the illegal/misaligned flag.
module riscv_lsu_align
  import riscv_lsu_pkg::*;
#(
  parameter  int DW = 32,
  localparam int BW = DW / 8,
  localparam int OW = $clog2(BW)
) (
  input  logic [2:0]    funct3,
  input  logic          wr,
  input  logic [OW-1:0] off,
  input  logic [DW-1:0] wdata,
  input  logic [DW-1:0] rdata,
  output logic [BW-1:0] be,
  output logic [DW-1:0] wdata_sh,
  output logic [DW-1:0] rdata_ext,
  output logic          bad
);

  logic [1:0]  sz;
  logic        sgn;
  logic [7:0]  amask;
  logic [63:0] sh64;
  logic [63:0] ext;
  logic        illegal;
  logic        misal;

  assign sz    = funct3[1:0];
  assign sgn   = ~funct3[2];
  assign amask = align_mask(sz);

  assign be       = BW'(size_mask(sz)) << off;
  assign wdata_sh = wdata << {off, 3'b000};

  // Widen to 64 bits so the extension cases are legal for both DW values.
  always_comb begin
    sh64 = 64'(rdata >> {off, 3'b000});
    case (sz)
      2'b00:   ext = {{56{sgn & sh64[7]}},  sh64[7:0]};
      2'b01:   ext = {{48{sgn & sh64[15]}}, sh64[15:0]};
      2'b10:   ext = {{32{sgn & sh64[31]}}, sh64[31:0]};
      default: ext = sh64;
    endcase
  end

  assign rdata_ext = ext[DW-1:0];

  assign illegal = (funct3 == F3_XX)
                 | (wr & funct3[2])
                 | ((funct3 == F3_D)  & (DW != 64))
                 | ((funct3 == F3_WU) & (DW != 64));
  assign misal   = |(off & amask[OW-1:0]);
  assign bad     = illegal | misal;

endmodule

// File: rtl/riscv_lsu.sv
// MEM-stage load/store unit: handshaked variable-latency memory port with
// sizing, extension, misalignment detection and a wait timeout.
module riscv_lsu
  import riscv_lsu_pkg::*;
#(
  parameter int DW       = 32,
  parameter int AW       = 32,
  parameter int MAX_WAIT = 255,
  parameter int CW       = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req_valid_i,
  input  logic               req_wr_i,
  input  logic [2:0]         req_funct3_i,
  input  logic [AW-1:0]      req_addr_i,
  input  logic [DW-1:0]      req_wdata_i,
  output logic               busy_o,
  output logic               rsp_valid_o,
  output logic [DW-1:0]      rsp_rdata_o,
  output logic               err_misalign_o,
  output logic               err_timeout_o,
  output logic               mem_req_o,
  output logic               mem_we_o,
  output logic [AW-1:0]      mem_addr_o,
  output logic [DW/8-1:0]    mem_be_o,
  output logic [DW-1:0]      mem_wdata_o,
  input  logic               mem_gnt_i,
  input  logic               mem_rvalid_i,
  input  logic [DW-1:0]      mem_rdata_i
);

  localparam int BW = lsu_dw_bytes(DW);
  localparam int OW = $clog2(BW);

  lsu_state_e    state, state_n;
  logic [CW-1:0] cnt;
  logic [2:0]    f3_q;
  logic [OW-1:0] off_q;
  logic          wr_q;

  logic [2:0]    a_f3;
  logic [OW-1:0] a_off;
  logic          a_wr;
  logic [BW-1:0] a_be;
  logic [DW-1:0] a_wdata;
  logic [DW-1:0] a_rdata;
  logic          a_bad;

  logic tmo, issue, fin, cap, set_mis, set_tmo;

  // In IDLE the live request is steered; afterwards the latched copy is.
  assign a_f3  = (state == ST_IDLE) ? req_funct3_i           : f3_q;
  assign a_off = (state == ST_IDLE) ? req_addr_i[OW-1:0]     : off_q;
  assign a_wr  = (state == ST_IDLE) ? req_wr_i               : wr_q;

  riscv_lsu_align #(.DW(DW)) u_align (
    .funct3    (a_f3),
    .wr        (a_wr),
    .off       (a_off),
    .wdata     (req_wdata_i),
    .rdata     (mem_rdata_i),
    .be        (a_be),
    .wdata_sh  (a_wdata),
    .rdata_ext (a_rdata),
    .bad       (a_bad)
  );

  // Fires on the last allowed REQ/WAIT cycle; >= also covers a load granted
  // on that last cycle, which then gets no extra slack in WAIT.
  assign tmo = (MAX_WAIT != 0) && ((int'(cnt) + 1) >= MAX_WAIT);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    issue   = 1'b0;
    fin     = 1'b0;
    cap     = 1'b0;
    set_mis = 1'b0;
    set_tmo = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_valid_i) begin
          if (a_bad) begin
            state_n = ST_RESP;
            fin     = 1'b1;
            set_mis = 1'b1;
          end else begin
            state_n = ST_REQ;
            issue   = 1'b1;
          end
        end
      end
      ST_REQ: begin
        if (mem_gnt_i) begin
          if (wr_q) begin
            state_n = ST_RESP;
            fin     = 1'b1;
          end else if (mem_rvalid_i) begin
            state_n = ST_RESP;
            fin     = 1'b1;
            cap     = 1'b1;
          end else begin
            state_n = ST_WAIT;
          end
        end else if (tmo) begin
          state_n = ST_RESP;
          fin     = 1'b1;
          set_tmo = 1'b1;
        end
      end
      ST_WAIT: begin
        if (mem_rvalid_i) begin
          state_n = ST_RESP;
          fin     = 1'b1;
          cap     = 1'b1;
        end else if (tmo) begin
          state_n = ST_RESP;
          fin     = 1'b1;
          set_tmo = 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign busy_o      = ((state == ST_IDLE) & req_valid_i) | (state == ST_REQ) | (state == ST_WAIT);
  assign rsp_valid_o = (state == ST_RESP);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt            <= '0;
      f3_q           <= '0;
      off_q          <= '0;
      wr_q           <= 1'b0;
      mem_req_o      <= 1'b0;
      mem_we_o       <= 1'b0;
      mem_addr_o     <= '0;
      mem_be_o       <= '0;
      mem_wdata_o    <= '0;
      rsp_rdata_o    <= '0;
      err_misalign_o <= 1'b0;
      err_timeout_o  <= 1'b0;
    end else begin
      if (state == ST_IDLE && req_valid_i) begin
        f3_q  <= req_funct3_i;
        off_q <= req_addr_i[OW-1:0];
        wr_q  <= req_wr_i;
      end

      if (issue) begin
        mem_req_o   <= 1'b1;
        mem_we_o    <= req_wr_i;
        mem_addr_o  <= {req_addr_i[AW-1:OW], {OW{1'b0}}};
        mem_be_o    <= a_be;
        mem_wdata_o <= a_wdata;
        cnt         <= '0;
      end else if (state == ST_REQ || state == ST_WAIT) begin
        cnt <= cnt + 1'b1;
      end

      // The port is released once granted or on timeout abort.
      if (state == ST_REQ && state_n != ST_REQ) begin
        mem_req_o   <= 1'b0;
        mem_we_o    <= 1'b0;
        mem_addr_o  <= '0;
        mem_be_o    <= '0;
        mem_wdata_o <= '0;
      end

      if (fin) begin
        rsp_rdata_o    <= cap ? a_rdata : '0;
        err_misalign_o <= set_mis;
        err_timeout_o  <= set_tmo;
      end else if (state == ST_RESP) begin
        rsp_rdata_o    <= '0;
        err_misalign_o <= 1'b0;
        err_timeout_o  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed bench for riscv_lsu (DW=32, MAX_WAIT=4) with a simple scripted
// memory responder.
module tb_riscv_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_wr = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        busy, rsp_valid, err_mis, err_tmo;
  logic [31:0] rsp_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  int n_chk = 0;
  int n_fail = 0;

  logic [3:0]  s_be;
  logic [31:0] s_wd, s_addr;
  logic        s_we;

  int          nbusy, nreq;
  logic        got, emis, etmo;
  logic [31:0] rd;

  always #5 clk = ~clk;

  riscv_lsu #(.DW(32), .AW(32), .MAX_WAIT(4), .CW(8)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_valid_i    (req_valid),
    .req_wr_i       (req_wr),
    .req_funct3_i   (req_funct3),
    .req_addr_i     (req_addr),
    .req_wdata_i    (req_wdata),
    .busy_o         (busy),
    .rsp_valid_o    (rsp_valid),
    .rsp_rdata_o    (rsp_rdata),
    .err_misalign_o (err_mis),
    .err_timeout_o  (err_tmo),
    .mem_req_o      (mem_req),
    .mem_we_o       (mem_we),
    .mem_addr_o     (mem_addr),
    .mem_be_o       (mem_be),
    .mem_wdata_o    (mem_wdata),
    .mem_gnt_i      (mem_gnt),
    .mem_rvalid_i   (mem_rvalid),
    .mem_rdata_i    (mem_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
    n_chk++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got_v, exp_v);
    end
  endtask

  // One access from IDLE. Grant on REQ cycle index gdly when gen=1; load
  // data returns the cycle after grant. Called at posedge+1.
  task automatic run(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] rdata,
                     input int gdly, input logic gen);
    logic gprev;
    nbusy = 0; nreq = 0; got = 1'b0; rd = '0; emis = 1'b0; etmo = 1'b0;
    s_be = '0; s_wd = '0; s_addr = '0; s_we = 1'b0;
    gprev = 1'b0;
    req_valid = 1'b1; req_wr = wr; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    for (int c = 0; c < 20 && !got; c++) begin
      mem_rvalid = gprev && !wr;
      mem_rdata  = rdata;
      mem_gnt    = 1'b0;
      if (mem_req) begin
        if (gen && nreq == gdly) mem_gnt = 1'b1;
        s_be = mem_be; s_wd = mem_wdata; s_addr = mem_addr; s_we = mem_we;
        nreq++;
      end
      gprev = mem_gnt;
      #1;
      if (busy) nbusy++;
      if (rsp_valid) begin
        got = 1'b1; rd = rsp_rdata; emis = err_mis; etmo = err_tmo;
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
  endtask

  initial begin
    int stray;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_be", mem_be, 0);
    chk("rst_rdata", rsp_rdata, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // LW aligned, minimum latency
    run(1'b0, 3'b010, 32'h104, 32'h0, 32'hDEADBEEF, 0, 1'b1);
    chk("lw_busy", nbusy, 3);
    chk("lw_got", got, 1);
    chk("lw_rdata", rd, 32'hDEADBEEF);
    chk("lw_be", s_be, 4'b1111);
    chk("lw_addr", s_addr, 32'h104);
    chk("lw_we", s_we, 0);
    chk("lw_err", {emis, etmo}, 0);

    // LB / LBU top byte
    run(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FFFF00, 0, 1'b1);
    chk("lb_be", s_be, 4'b1000);
    chk("lb_addr", s_addr, 32'h100);
    chk("lb_rdata", rd, 32'hFFFFFF80);
    run(1'b0, 3'b100, 32'h103, 32'h0, 32'h80FFFF00, 0, 1'b1);
    chk("lbu_rdata", rd, 32'h00000080);

    // LH / LHU upper half
    run(1'b0, 3'b001, 32'h102, 32'h0, 32'h80010000, 0, 1'b1);
    chk("lh_be", s_be, 4'b1100);
    chk("lh_rdata", rd, 32'hFFFF8001);
    run(1'b0, 3'b101, 32'h102, 32'h0, 32'h80010000, 0, 1'b1);
    chk("lhu_rdata", rd, 32'h00008001);

    // SH upper half
    run(1'b1, 3'b001, 32'h202, 32'h0000ABCD, 32'h0, 0, 1'b1);
    chk("sh_busy", nbusy, 2);
    chk("sh_be", s_be, 4'b1100);
    chk("sh_wdata", s_wd, 32'hABCD0000);
    chk("sh_we", s_we, 1);
    chk("sh_got", got, 1);
    chk("sh_rdata", rd, 0);

    // SB lane 1
    run(1'b1, 3'b000, 32'h301, 32'h00000012, 32'h0, 0, 1'b1);
    chk("sb_be", s_be, 4'b0010);
    chk("sb_wdata", s_wd, 32'h00001200);

    // Misaligned and illegal sizes
    run(1'b0, 3'b010, 32'h102, 32'h0, 32'h0, 0, 1'b1);
    chk("mis_nreq", nreq, 0);
    chk("mis_busy", nbusy, 1);
    chk("mis_got", got, 1);
    chk("mis_err", emis, 1);
    chk("mis_rdata", rd, 0);
    run(1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 0, 1'b1);
    chk("ld32_nreq", nreq, 0);
    chk("ld32_err", emis, 1);
    run(1'b0, 3'b110, 32'h100, 32'h0, 32'h0, 0, 1'b1);
    chk("lwu32_err", emis, 1);
    run(1'b1, 3'b100, 32'h100, 32'h0, 32'h0, 0, 1'b1);
    chk("st_f3_err", emis, 1);
    chk("st_f3_nreq", nreq, 0);

    // Timeout: never granted
    run(1'b0, 3'b010, 32'h100, 32'h0, 32'h12345678, 0, 1'b0);
    chk("tmo_nreq", nreq, 4);
    chk("tmo_got", got, 1);
    chk("tmo_err", etmo, 1);
    chk("tmo_mis", emis, 0);
    chk("tmo_rdata", rd, 0);
    chk("tmo_req_low", mem_req, 0);

    // Grant on the last allowed cycle wins over the timeout
    run(1'b1, 3'b010, 32'h300, 32'h11223344, 32'h0, 3, 1'b1);
    chk("late_nreq", nreq, 4);
    chk("late_got", got, 1);
    chk("late_tmo", etmo, 0);
    chk("late_wdata", s_wd, 32'h11223344);

    // Reset in WAIT, then a stray rvalid
    req_valid = 1'b1; req_wr = 1'b0; req_funct3 = 3'b010; req_addr = 32'h104;
    @(posedge clk); #1;
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    #2;
    rst = 1'b1; req_valid = 1'b0;
    #1;
    chk("rstw_mem_req", mem_req, 0);
    chk("rstw_busy", busy, 0);
    chk("rstw_rsp_valid", rsp_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
    stray = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
      if (rsp_valid) stray++;
    end
    chk("rstw_stray_rsp", stray, 0);
    run(1'b0, 3'b010, 32'h108, 32'h0, 32'h0BADF00D, 0, 1'b1);
    chk("post_rst_busy", nbusy, 3);
    chk("post_rst_rdata", rd, 32'h0BADF00D);
    chk("post_rst_addr", s_addr, 32'h108);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
